// File: rtl/sounder_frame_gen_if.sv
// Control and AXI-Stream sample bus of the channel-sounder frame generator.
// master = generator side, slave = controller / DSP consumer side.
interface sounder_frame_gen_if #(
  parameter int DATA_W = 16
);
  logic              start;
  logic              stop;
  logic [15:0]       frame_count;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              busy;
  logic              run_done;

  modport master (
    input  start, stop, frame_count, m_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, run_done
  );

  modport slave (
    output start, stop, frame_count, m_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, busy, run_done
  );
endinterface

// File: rtl/sounder_frame_gen.sv
// Frame source: SEQ_LEN BPSK m-sequence samples then GUARD_LEN zeros, repeated per run.
// 1-cycle start latency; registered outputs hold while tvalid && !tready, no bubbles inside a run.
module sounder_frame_gen #(
  parameter int                       DATA_W    = 16,
  parameter int                       SEQ_LEN   = 32,
  parameter int                       GUARD_LEN = 8,
  parameter int                       LFSR_W    = 7,
  parameter logic [LFSR_W-1:0]        LFSR_TAPS = 7'h60,
  parameter logic [LFSR_W-1:0]        LFSR_SEED = 7'h7F,
  parameter logic signed [DATA_W-1:0] AMP       = 16'sd8192
) (
  input  logic                 aclk,
  input  logic                 areset,
  sounder_frame_gen_if.master  bus
);

  localparam int TOTAL = SEQ_LEN + GUARD_LEN;
  localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);
  localparam logic [IDX_W-1:0] SEQ_END  = IDX_W'(SEQ_LEN - 1);

  typedef enum logic [1:0] {IDLE, SEQ, GUARD} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

  function automatic logic [DATA_W-1:0] bpsk(input logic [LFSR_W-1:0] l);
    return l[LFSR_W-1] ? AMP : -AMP;
  endfunction

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [15:0]         r_frames_sent;
  logic [15:0]         r_frame_count;
  logic                r_stop;
  logic [DATA_W-1:0]   r_tdata;
  logic                r_tvalid;
  logic                r_tlast;
  logic                r_busy;
  logic                r_run_done;

  logic                w_xfer;
  logic                w_last;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic [LFSR_W-1:0]   w_lfsr_nxt;
  logic                w_in_seq_nxt;
  logic [15:0]         w_frames_nxt;
  logic                w_run_end;

  // r_idx/r_lfsr describe the beat currently presented; the next beat is prepared on transfer.
  assign w_xfer       = r_tvalid & bus.m_axis_tready;
  assign w_last       = (r_idx == LAST_IDX);
  assign w_idx_nxt    = r_idx + IDX_W'(1);
  assign w_lfsr_nxt   = (r_state == SEQ) ? lfsr_step(r_lfsr) : r_lfsr;
  assign w_in_seq_nxt = (r_idx < SEQ_END);
  assign w_frames_nxt = r_frames_sent + 16'd1;
  assign w_run_end    = r_stop | bus.stop |
                        ((r_frame_count != 16'd0) && (w_frames_nxt == r_frame_count));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_lfsr        <= LFSR_SEED;
      r_frames_sent <= '0;
      r_frame_count <= '0;
      r_stop        <= 1'b0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_busy        <= 1'b0;
      r_run_done    <= 1'b0;
    end else begin
      r_run_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_stop <= 1'b0;
          if (bus.start) begin
            r_state       <= SEQ;
            r_idx         <= '0;
            r_lfsr        <= LFSR_SEED;
            r_frames_sent <= '0;
            r_frame_count <= bus.frame_count;
            r_tdata       <= bpsk(LFSR_SEED);
            r_tvalid      <= 1'b1;
            r_tlast       <= (LAST_IDX == '0);
            r_busy        <= 1'b1;
          end
        end
        SEQ, GUARD: begin
          if (bus.stop) r_stop <= 1'b1;
          if (w_xfer) begin
            if (!w_last) begin
              r_idx   <= w_idx_nxt;
              r_lfsr  <= w_lfsr_nxt;
              r_tlast <= (w_idx_nxt == LAST_IDX);
              if (w_in_seq_nxt) begin
                r_state <= SEQ;
                r_tdata <= bpsk(w_lfsr_nxt);
              end else begin
                r_state <= GUARD;
                r_tdata <= '0;
              end
            end else begin
              r_frames_sent <= w_frames_nxt;
              r_idx         <= '0;
              r_lfsr        <= LFSR_SEED;
              if (w_run_end) begin
                r_state    <= IDLE;
                r_tdata    <= '0;
                r_tvalid   <= 1'b0;
                r_tlast    <= 1'b0;
                r_busy     <= 1'b0;
                r_run_done <= 1'b1;
                r_stop     <= 1'b0;
              end else begin
                // Next frame starts on the very next cycle so there is no bubble.
                r_state <= SEQ;
                r_tdata <= bpsk(LFSR_SEED);
                r_tlast <= (LAST_IDX == '0);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_axis_tdata  = r_tdata;
  assign bus.m_axis_tvalid = r_tvalid;
  assign bus.m_axis_tlast  = r_tlast;
  assign bus.busy          = r_busy;
  assign bus.run_done      = r_run_done;

endmodule

// File: tb/tb_sounder_frame_gen.sv
// Randomized bench for sounder_frame_gen against a frame-level reference model.
module tb_sounder_frame_gen;
  localparam int FRAME = 40;
  localparam int SEQ   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sounder_frame_gen_if #(.DATA_W(16)) bus();

  sounder_frame_gen dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_frame [FRAME];
  logic [15:0] q_data [$];
  logic        q_last [$];
  int          first_cyc, last_cyc, done_cyc, n_done, bubbles, stall_bad;
  logic        busy_at_done;

  // Reference frame: m-sequence bits mapped to +/-8192, then zero guard samples.
  function automatic void build_model();
    int l = 'h7F;
    int b, fb;
    for (int i = 0; i < FRAME; i++) begin
      if (i < SEQ) begin
        b  = (l >> 6) & 1;
        exp_frame[i] = b ? 16'h2000 : 16'hE000;
        fb = ((l >> 6) ^ (l >> 5)) & 1;
        l  = ((l << 1) | fb) & 'h7F;
      end else begin
        exp_frame[i] = 16'h0000;
      end
    end
  endfunction

  task automatic do_start(input logic [15:0] fc);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.frame_count = fc;
  endtask

  task automatic collect(input int budget, input bit rnd, input int stop_beat,
                         input int start_beat, input logic [15:0] fc2, input int max_beats);
    logic [15:0] pd;
    logic        pl;
    bit          pstall;
    q_data.delete();
    q_last.delete();
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    n_done = 0; bubbles = 0; stall_bad = 0; busy_at_done = 1'bx;
    pstall = 0; pd = '0; pl = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (pstall && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== pd ||
                     bus.m_axis_tlast !== pl))
        stall_bad++;
      if (bus.run_done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc     = c;
          busy_at_done = bus.busy;
        end
      end
      if (bus.busy === 1'b1 && bus.m_axis_tvalid !== 1'b1) bubbles++;
      bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
        if (q_data.size() == stop_beat) bus.stop = 1'b1;
        if (q_data.size() == start_beat) begin
          bus.start       = 1'b1;
          bus.frame_count = fc2;
        end
        if (first_cyc < 0) first_cyc = c;
        q_data.push_back(bus.m_axis_tdata);
        q_last.push_back(bus.m_axis_tlast);
        last_cyc = c;
        if (q_data.size() == max_beats) return;
      end
      pstall = (bus.m_axis_tvalid === 1'b1) && !bus.m_axis_tready;
      pd     = bus.m_axis_tdata;
      pl     = bus.m_axis_tlast;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
  endtask

  task automatic test_reset();
    total++;
    if (bus.m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", bus.m_axis_tvalid); end
    total++;
    if (bus.m_axis_tdata !== 16'h0000) begin bad++; $display("FAIL reset_tdata got=%h exp=0000", bus.m_axis_tdata); end
    total++;
    if (bus.m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got=%b exp=0", bus.m_axis_tlast); end
    total++;
    if (bus.busy !== 1'b0 || bus.run_done !== 1'b0) begin
      bad++; $display("FAIL reset_busy_done got=%b%b exp=00", bus.busy, bus.run_done);
    end
  endtask

  task automatic test_single_frame();
    do_start(16'd1);
    collect(500, 0, -1, -1, 16'd0, -1);
    total++;
    if (first_cyc !== 0) begin bad++; $display("FAIL t1_latency got=%0d exp=0", first_cyc); end
    total++;
    if (q_data.size() != FRAME) begin bad++; $display("FAIL t1_beats got=%0d exp=%0d", q_data.size(), FRAME); end
    total++;
    if (q_data.size() > 0 && q_data[0] !== 16'h2000) begin bad++; $display("FAIL t1_beat0 got=%h exp=2000", q_data[0]); end
    for (int i = 0; i < q_data.size() && i < FRAME; i++) begin
      total++;
      if (q_data[i] !== exp_frame[i] || q_last[i] !== (i == FRAME - 1)) begin
        bad++; $display("FAIL t1_beat%0d got=%h/%b exp=%h/%b", i, q_data[i], q_last[i], exp_frame[i], i == FRAME - 1);
      end
    end
    total++;
    if (done_cyc != last_cyc + 1 || n_done != 1) begin
      bad++; $display("FAIL t1_run_done got_cyc=%0d pulses=%0d exp_cyc=%0d pulses=1", done_cyc, n_done, last_cyc + 1);
    end
  endtask

  task automatic test_multi_frame();
    do_start(16'd3);
    collect(1000, 0, -1, -1, 16'd0, -1);
    total++;
    if (q_data.size() != 3 * FRAME) begin bad++; $display("FAIL t2_beats got=%0d exp=%0d", q_data.size(), 3 * FRAME); end
    for (int i = 0; i < q_data.size() && i < 3 * FRAME; i++) begin
      total++;
      if (q_data[i] !== exp_frame[i % FRAME] || q_last[i] !== (i % FRAME == FRAME - 1)) begin
        bad++; $display("FAIL t2_beat%0d got=%h/%b exp=%h/%b", i, q_data[i], q_last[i], exp_frame[i % FRAME], i % FRAME == FRAME - 1);
      end
    end
    total++;
    if (last_cyc - first_cyc != 3 * FRAME - 1 || bubbles != 0) begin
      bad++; $display("FAIL t2_contiguous got_span=%0d bubbles=%0d exp_span=%0d bubbles=0", last_cyc - first_cyc, bubbles, 3 * FRAME - 1);
    end
    total++;
    if (busy_at_done !== 1'b0 || done_cyc != last_cyc + 1) begin
      bad++; $display("FAIL t2_busy_end got=%b cyc=%0d exp=0 cyc=%0d", busy_at_done, done_cyc, last_cyc + 1);
    end
  endtask

  task automatic test_random_ready();
    do_start(16'd2);
    collect(3000, 1, -1, -1, 16'd0, -1);
    bus.m_axis_tready = 1'b1;
    total++;
    if (q_data.size() != 2 * FRAME) begin bad++; $display("FAIL t3_beats got=%0d exp=%0d", q_data.size(), 2 * FRAME); end
    for (int i = 0; i < q_data.size() && i < 2 * FRAME; i++) begin
      total++;
      if (q_data[i] !== exp_frame[i % FRAME] || q_last[i] !== (i % FRAME == FRAME - 1)) begin
        bad++; $display("FAIL t3_beat%0d got=%h/%b exp=%h/%b", i, q_data[i], q_last[i], exp_frame[i % FRAME], i % FRAME == FRAME - 1);
      end
    end
    total++;
    if (stall_bad != 0) begin bad++; $display("FAIL t3_stall_hold got=%0d exp=0", stall_bad); end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL t3_run_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_stop();
    do_start(16'd0);
    collect(1000, 0, 50, -1, 16'd0, -1);
    total++;
    if (q_data.size() != 2 * FRAME) begin bad++; $display("FAIL t4_beats got=%0d exp=%0d", q_data.size(), 2 * FRAME); end
    total++;
    if (q_last.size() >= 2 * FRAME && (q_last[2 * FRAME - 1] !== 1'b1 || q_last[FRAME - 1] !== 1'b1)) begin
      bad++; $display("FAIL t4_tlast got=%b/%b exp=1/1", q_last[FRAME - 1], q_last[2 * FRAME - 1]);
    end
    total++;
    if (done_cyc != last_cyc + 1 || n_done != 1 || busy_at_done !== 1'b0) begin
      bad++; $display("FAIL t4_run_done got_cyc=%0d pulses=%0d busy=%b exp_cyc=%0d", done_cyc, n_done, busy_at_done, last_cyc + 1);
    end
  endtask

  task automatic test_areset();
    do_start(16'd1);
    collect(500, 0, -1, -1, 16'd0, 21);
    rst = 1'b1;
    #1;
    total++;
    if (bus.m_axis_tvalid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL t5_async_drop got=%b%b exp=00", bus.m_axis_tvalid, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat ($urandom_range(1, 4)) @(negedge clk);
    do_start(16'd1);
    collect(500, 0, -1, -1, 16'd0, -1);
    total++;
    if (q_data.size() != FRAME) begin bad++; $display("FAIL t5_beats got=%0d exp=%0d", q_data.size(), FRAME); end
    total++;
    if (q_data.size() > 0 && q_data[0] !== 16'h2000) begin bad++; $display("FAIL t5_beat0 got=%h exp=2000", q_data[0]); end
    total++;
    if (q_last.size() >= FRAME && q_last[FRAME - 1] !== 1'b1) begin bad++; $display("FAIL t5_tlast got=%b exp=1", q_last[FRAME - 1]); end
  endtask

  task automatic test_start_ignored();
    do_start(16'd1);
    collect(1000, 0, -1, 10, 16'd5, -1);
    total++;
    if (q_data.size() != FRAME) begin bad++; $display("FAIL t6_beats got=%0d exp=%0d", q_data.size(), FRAME); end
    total++;
    if (n_done != 1 || done_cyc != last_cyc + 1) begin
      bad++; $display("FAIL t6_run_done got=%0d cyc=%0d exp=1 cyc=%0d", n_done, done_cyc, last_cyc + 1);
    end
    for (int i = 0; i < q_data.size() && i < FRAME; i++) begin
      total++;
      if (q_data[i] !== exp_frame[i]) begin bad++; $display("FAIL t6_beat%0d got=%h exp=%h", i, q_data[i], exp_frame[i]); end
    end
  endtask

  initial begin
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.frame_count   = 16'd0;
    bus.m_axis_tready = 1'b1;
    build_model();
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    test_single_frame();
    test_multi_frame();
    test_random_ready();
    test_stop();
    test_areset();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
